// File: rtl/sparc_rf_pkg.sv
// Shared types and constants for the windowed SPARC integer register file.
// Holds default sizes, logical region bases and the physical depth helper.
package sparc_rf_pkg;

   localparam int DATA_W_DEFAULT   = 32;
   localparam int NWINDOWS_DEFAULT = 8;

   // Logical region bases within a 32-register window view
   localparam logic [4:0] REG_G = 5'd0;
   localparam logic [4:0] REG_O = 5'd8;
   localparam logic [4:0] REG_L = 5'd16;
   localparam logic [4:0] REG_I = 5'd24;

   typedef logic [4:0] log_addr_t;

   typedef enum logic [1:0] {
      WIN_OP_NONE,
      WIN_OP_SAVE,
      WIN_OP_RESTORE,
      WIN_OP_BOTH
   } win_op_e;

   function automatic int phys_depth(input int nw);
      return 8 + 16 * nw;
   endfunction

endpackage

// File: rtl/sparc_win_addr_map.sv
// Combinational logical-address + CWP to physical-index translation.
// Globals map straight through; ins alias the outs of window (cwp+1).
module sparc_win_addr_map
   import sparc_rf_pkg::*;
#(
   parameter int NWINDOWS = NWINDOWS_DEFAULT,
   parameter int CWP_W    = $clog2(NWINDOWS),
   parameter int PHYS_W   = CWP_W + 5
) (
   input  log_addr_t         addr,
   input  logic [CWP_W-1:0]  cwp,
   output logic [PHYS_W-1:0] phys,
   output logic              is_g0
);

   logic [CWP_W-1:0] win;
   logic             is_local;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      win      = cwp;
      is_local = 1'b0;
      phys     = '0;
      if (addr >= REG_I) begin
         // NWINDOWS is a power of two, so the CWP_W-bit add wraps modulo NWINDOWS.
         win = cwp + 1'b1;
      end else if (addr >= REG_L) begin
         is_local = 1'b1;
      end
      if (addr < REG_O) begin
         phys = PHYS_W'(addr);
      end else begin
         phys = PHYS_W'({win, is_local, addr[2:0]}) + PHYS_W'(8);
      end
   end

   assign is_g0 = (addr == REG_G);

endmodule

// File: rtl/sparc_win_regfile.sv
// Windowed SPARC integer register file with CWP/WIM control and trap pulses.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to matching read ports.
module sparc_win_regfile
   import sparc_rf_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEFAULT,
   parameter int NWINDOWS = NWINDOWS_DEFAULT,
   parameter int CWP_W    = $clog2(NWINDOWS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  log_addr_t           rs1_addr,
   input  log_addr_t           rs2_addr,
   output logic [DATA_W-1:0]   rs1_data,
   output logic [DATA_W-1:0]   rs2_data,
   input  logic                rd_we,
   input  log_addr_t           rd_addr,
   input  logic [DATA_W-1:0]   rd_data,
   input  logic                save,
   input  logic                restore,
   input  logic                wim_we,
   input  logic [NWINDOWS-1:0] wim_wdata,
   output logic [CWP_W-1:0]    cwp,
   output logic [NWINDOWS-1:0] wim,
   output logic                trap_ovf,
   output logic                trap_unf,
   output logic                sr_err
);

   localparam int DEPTH  = phys_depth(NWINDOWS);
   localparam int PHYS_W = CWP_W + 5;

   logic [DATA_W-1:0] regs [DEPTH];

   logic [PHYS_W-1:0] rs1_phys, rs2_phys, rd_phys;
   logic              rs1_g0, rs2_g0, rd_g0;
   logic              rd_commit;
   logic [DATA_W-1:0] rs1_next, rs2_next;

   sparc_win_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W)) u_map_rs1 (
      .addr  (rs1_addr),
      .cwp   (cwp),
      .phys  (rs1_phys),
      .is_g0 (rs1_g0)
   );

   sparc_win_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W)) u_map_rs2 (
      .addr  (rs2_addr),
      .cwp   (cwp),
      .phys  (rs2_phys),
      .is_g0 (rs2_g0)
   );

   sparc_win_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W)) u_map_rd (
      .addr  (rd_addr),
      .cwp   (cwp),
      .phys  (rd_phys),
      .is_g0 (rd_g0)
   );

   assign rd_commit = rd_we && !rd_g0;

   // NOTE: the array has no reset so it can map onto RAM; only control state is reset.
   always_ff @(posedge clk) begin
      if (rd_commit) begin
         regs[rd_phys] <= rd_data;
      end
   end

   always_comb begin
      rs1_next = rs1_g0 ? '0 : regs[rs1_phys];
      rs2_next = rs2_g0 ? '0 : regs[rs2_phys];
`ifdef REGFILE_BYPASS_EN
      // rd_commit already excludes g0, and a g0 read can never match a non-g0 index.
      if (rd_commit && (rd_phys == rs1_phys)) rs1_next = rd_data;
      if (rd_commit && (rd_phys == rs2_phys)) rs2_next = rd_data;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_data <= '0;
         rs2_data <= '0;
      end else begin
         rs1_data <= rs1_next;
         rs2_data <= rs2_next;
      end
   end

   win_op_e          win_op;
   logic [CWP_W-1:0] save_tgt, restore_tgt;
   logic [CWP_W-1:0] cwp_d;
   logic             ovf_d, unf_d, err_d;

   assign win_op      = win_op_e'({restore, save});
   assign save_tgt    = cwp - 1'b1;
   assign restore_tgt = cwp + 1'b1;

   // Trap checks use the WIM register value, so a same-cycle wim_we only affects later ops.
   always_comb begin
      cwp_d = cwp;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      err_d = 1'b0;
      case (win_op)
         WIN_OP_SAVE: begin
            if (wim[save_tgt]) ovf_d = 1'b1;
            else               cwp_d = save_tgt;
         end
         WIN_OP_RESTORE: begin
            if (wim[restore_tgt]) unf_d = 1'b1;
            else                  cwp_d = restore_tgt;
         end
         WIN_OP_BOTH: err_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cwp      <= '0;
         wim      <= '0;
         trap_ovf <= 1'b0;
         trap_unf <= 1'b0;
         sr_err   <= 1'b0;
      end else begin
         cwp      <= cwp_d;
         trap_ovf <= ovf_d;
         trap_unf <= unf_d;
         sr_err   <= err_d;
         if (wim_we) wim <= wim_wdata;
      end
   end

endmodule

// File: tb/tb_sparc_win_regfile.sv
// Self-checking bench for sparc_win_regfile against a window-arithmetic reference model.
// Honours REGFILE_BYPASS_EN the same way as the design.
module tb_sparc_win_regfile;

   localparam int NW    = 8;
   localparam int DW    = 32;
   localparam int CW    = 3;
   localparam int DEPTH = 8 + 16 * NW;

   logic          clk;
   logic          rst_n;
   logic [4:0]    rs1_addr, rs2_addr, rd_addr;
   logic [DW-1:0] rs1_data, rs2_data, rd_data;
   logic          rd_we, save, restore, wim_we;
   logic [NW-1:0] wim_wdata, wim;
   logic [CW-1:0] cwp;
   logic          trap_ovf, trap_unf, sr_err;

   sparc_win_regfile #(.DATA_W(DW), .NWINDOWS(NW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .rd_we     (rd_we),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .save      (save),
      .restore   (restore),
      .wim_we    (wim_we),
      .wim_wdata (wim_wdata),
      .cwp       (cwp),
      .wim       (wim),
      .trap_ovf  (trap_ovf),
      .trap_unf  (trap_unf),
      .sr_err    (sr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [DW-1:0] mem [DEPTH];
   int            m_cwp;
   logic [NW-1:0] m_wim;
   logic [DW-1:0] exp_rs1, exp_rs2;
   logic          exp_ovf, exp_unf, exp_err;

   int n_cmp = 0;
   int n_err = 0;

   function automatic int mphys(input int a, input int w);
      if (a < 8)  return a;
      if (a < 16) return 8 + 16 * w + (a - 8);
      if (a < 24) return 8 + 16 * w + 8 + (a - 16);
      return 8 + 16 * ((w + 1) % NW) + (a - 24);
   endfunction

   task automatic model_reset();
      m_cwp   = 0;
      m_wim   = '0;
      exp_rs1 = '0;
      exp_rs2 = '0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      exp_err = 1'b0;
   endtask

   task automatic clear_inputs();
      rs1_addr  = '0;
      rs2_addr  = '0;
      rd_we     = 1'b0;
      rd_addr   = '0;
      rd_data   = '0;
      save      = 1'b0;
      restore   = 1'b0;
      wim_we    = 1'b0;
      wim_wdata = '0;
   endtask

   // One clock: drive inputs, advance the model on the edge, return at the next negedge.
   task automatic cycle(input int a1, input int a2, input bit we, input int ad,
                        input logic [DW-1:0] d, input bit sv, input bit rs,
                        input bit ww, input logic [NW-1:0] wd);
      int p1, p2, pd, t;
      rs1_addr  = 5'(a1);
      rs2_addr  = 5'(a2);
      rd_we     = we;
      rd_addr   = 5'(ad);
      rd_data   = d;
      save      = sv;
      restore   = rs;
      wim_we    = ww;
      wim_wdata = wd;
      @(posedge clk);
      p1 = mphys(a1, m_cwp);
      p2 = mphys(a2, m_cwp);
      pd = mphys(ad, m_cwp);
      exp_rs1 = (a1 == 0) ? '0 : mem[p1];
      exp_rs2 = (a2 == 0) ? '0 : mem[p2];
`ifdef REGFILE_BYPASS_EN
      if (we && ad != 0 && a1 != 0 && pd == p1) exp_rs1 = d;
      if (we && ad != 0 && a2 != 0 && pd == p2) exp_rs2 = d;
`endif
      if (we && ad != 0) mem[pd] = d;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      exp_err = 1'b0;
      if (sv && rs) begin
         exp_err = 1'b1;
      end else if (sv) begin
         t = (m_cwp + NW - 1) % NW;
         if (m_wim[t]) exp_ovf = 1'b1;
         else          m_cwp = t;
      end else if (rs) begin
         t = (m_cwp + 1) % NW;
         if (m_wim[t]) exp_unf = 1'b1;
         else          m_cwp = t;
      end
      if (ww) m_wim = wd;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, '0, 0, 0, 0, '0);
   endtask

   task automatic wr(input int ad, input logic [DW-1:0] d);
      cycle(0, 0, 1, ad, d, 0, 0, 0, '0);
   endtask

   task automatic set_wim(input logic [NW-1:0] wd);
      cycle(0, 0, 0, 0, '0, 0, 0, 1, wd);
   endtask

   // Walk CWP upward with RESTOREs; caller guarantees WIM is clear.
   task automatic goto_cwp(input int target);
      for (int i = 0; i < NW && m_cwp != target; i++) cycle(0, 0, 0, 0, '0, 0, 1, 0, '0);
   endtask

   task automatic fill_all();
      set_wim('0);
      for (int a = 1; a < 8; a++) wr(a, $urandom);
      for (int w = 0; w < NW; w++) begin
         goto_cwp(w);
         for (int a = 8; a < 24; a++) wr(a, $urandom);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      #13;
      n_cmp += 7;
      if (rs1_data !== '0) begin n_err++; $display("FAIL reset_rs1 got %h want 0", rs1_data); end
      if (rs2_data !== '0) begin n_err++; $display("FAIL reset_rs2 got %h want 0", rs2_data); end
      if (cwp !== '0)      begin n_err++; $display("FAIL reset_cwp got %0d want 0", cwp); end
      if (wim !== '0)      begin n_err++; $display("FAIL reset_wim got %h want 0", wim); end
      if (trap_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", trap_ovf); end
      if (trap_unf !== 1'b0) begin n_err++; $display("FAIL reset_unf got %b want 0", trap_unf); end
      if (sr_err !== 1'b0)   begin n_err++; $display("FAIL reset_err got %b want 0", sr_err); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_globals();
      goto_cwp(0);
      wr(1, 32'hDEAD_BEEF);
      cycle(0, 0, 0, 0, '0, 1, 0, 0, '0);
      cycle(1, 1, 0, 0, '0, 0, 0, 0, '0);
      n_cmp += 3;
      if (cwp !== CW'(7)) begin n_err++; $display("FAIL glob_cwp got %0d want 7", cwp); end
      if (rs1_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL glob_r1 got %h want deadbeef", rs1_data); end
      if (rs2_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL glob_r1_p2 got %h want deadbeef", rs2_data); end
      wr(0, 32'h5);
      cycle(0, 0, 0, 0, '0, 0, 0, 0, '0);
      n_cmp++;
      if (rs1_data !== '0) begin n_err++; $display("FAIL glob_r0 got %h want 0", rs1_data); end
   endtask

   task automatic test_overlap();
      logic [DW-1:0] v16;
      v16 = $urandom;
      goto_cwp(2);
      wr(8, 32'h1234);
      wr(16, v16);
      cycle(0, 0, 0, 0, '0, 1, 0, 0, '0);
      cycle(24, 0, 0, 0, '0, 0, 0, 0, '0);
      n_cmp += 2;
      if (cwp !== CW'(1)) begin n_err++; $display("FAIL ovl_cwp got %0d want 1", cwp); end
      if (rs1_data !== 32'h1234) begin n_err++; $display("FAIL ovl_r24 got %h want 1234", rs1_data); end
      cycle(0, 0, 0, 0, '0, 0, 1, 0, '0);
      cycle(0, 16, 0, 0, '0, 0, 0, 0, '0);
      n_cmp += 2;
      if (cwp !== CW'(2)) begin n_err++; $display("FAIL ovl_cwp_back got %0d want 2", cwp); end
      if (rs2_data !== v16) begin n_err++; $display("FAIL ovl_r16 got %h want %h", rs2_data, v16); end
   endtask

   task automatic test_wrap();
      goto_cwp(0);
      cycle(0, 0, 0, 0, '0, 1, 0, 0, '0);
      n_cmp++;
      if (cwp !== CW'(7)) begin n_err++; $display("FAIL wrap_save got %0d want 7", cwp); end
      cycle(0, 0, 0, 0, '0, 0, 1, 0, '0);
      n_cmp++;
      if (cwp !== CW'(0)) begin n_err++; $display("FAIL wrap_restore got %0d want 0", cwp); end
   endtask

   task automatic test_traps();
      set_wim('0);
      goto_cwp(3);
      set_wim(8'h04);
      cycle(0, 0, 0, 0, '0, 1, 0, 0, '0);
      n_cmp += 3;
      if (trap_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pulse got %b want 1", trap_ovf); end
      if (trap_unf !== 1'b0) begin n_err++; $display("FAIL ovf_no_unf got %b want 0", trap_unf); end
      if (cwp !== CW'(3))    begin n_err++; $display("FAIL ovf_cwp got %0d want 3", cwp); end
      idle();
      n_cmp++;
      if (trap_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", trap_ovf); end
      set_wim(8'h10);
      cycle(0, 0, 0, 0, '0, 0, 1, 0, '0);
      n_cmp += 2;
      if (trap_unf !== 1'b1) begin n_err++; $display("FAIL unf_pulse got %b want 1", trap_unf); end
      if (cwp !== CW'(3))    begin n_err++; $display("FAIL unf_cwp got %0d want 3", cwp); end
      idle();
      n_cmp++;
      if (trap_unf !== 1'b0) begin n_err++; $display("FAIL unf_clear got %b want 0", trap_unf); end
   endtask

   task automatic test_wim_same_cycle();
      set_wim('0);
      goto_cwp(3);
      cycle(0, 0, 0, 0, '0, 1, 0, 1, 8'h04);
      n_cmp += 3;
      if (cwp !== CW'(2))    begin n_err++; $display("FAIL wimsc_cwp got %0d want 2", cwp); end
      if (trap_ovf !== 1'b0) begin n_err++; $display("FAIL wimsc_ovf got %b want 0", trap_ovf); end
      if (wim !== 8'h04)     begin n_err++; $display("FAIL wimsc_wim got %h want 04", wim); end
      cycle(0, 0, 0, 0, '0, 0, 1, 0, '0);
      cycle(0, 0, 0, 0, '0, 1, 0, 0, '0);
      n_cmp += 2;
      if (trap_ovf !== 1'b1) begin n_err++; $display("FAIL wimsc_ovf_new got %b want 1", trap_ovf); end
      if (cwp !== CW'(3))    begin n_err++; $display("FAIL wimsc_cwp_new got %0d want 3", cwp); end
   endtask

   task automatic test_bypass();
      logic [DW-1:0] old, want;
      old = mem[mphys(17, m_cwp)];
      cycle(17, 0, 1, 17, 32'hA5A5, 0, 0, 0, '0);
`ifdef REGFILE_BYPASS_EN
      want = 32'hA5A5;
`else
      want = old;
`endif
      n_cmp++;
      if (rs1_data !== want) begin n_err++; $display("FAIL byp_same got %h want %h", rs1_data, want); end
      cycle(17, 0, 0, 0, '0, 0, 0, 0, '0);
      n_cmp++;
      if (rs1_data !== 32'hA5A5) begin n_err++; $display("FAIL byp_next got %h want a5a5", rs1_data); end
      cycle(0, 0, 1, 0, 32'hFFFF, 0, 0, 0, '0);
      n_cmp++;
      if (rs1_data !== '0) begin n_err++; $display("FAIL byp_r0 got %h want 0", rs1_data); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
               $urandom_range(0, 31), $urandom, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, NW'($urandom));
         n_cmp += 7;
         if (rs1_data !== exp_rs1) begin n_err++; $display("FAIL rnd_rs1 @%0d got %h want %h", i, rs1_data, exp_rs1); end
         if (rs2_data !== exp_rs2) begin n_err++; $display("FAIL rnd_rs2 @%0d got %h want %h", i, rs2_data, exp_rs2); end
         if (cwp !== CW'(m_cwp))   begin n_err++; $display("FAIL rnd_cwp @%0d got %0d want %0d", i, cwp, m_cwp); end
         if (wim !== m_wim)        begin n_err++; $display("FAIL rnd_wim @%0d got %h want %h", i, wim, m_wim); end
         if (trap_ovf !== exp_ovf) begin n_err++; $display("FAIL rnd_ovf @%0d got %b want %b", i, trap_ovf, exp_ovf); end
         if (trap_unf !== exp_unf) begin n_err++; $display("FAIL rnd_unf @%0d got %b want %b", i, trap_unf, exp_unf); end
         if (sr_err !== exp_err)   begin n_err++; $display("FAIL rnd_err @%0d got %b want %b", i, sr_err, exp_err); end
      end
   endtask

   task automatic test_sr_err();
      set_wim('0);
      goto_cwp(5);
      wr(1, 32'h600D_F00D);
      cycle(1, 0, 0, 0, '0, 1, 1, 0, '0);
      n_cmp += 5;
      if (sr_err !== 1'b1)   begin n_err++; $display("FAIL sr_pulse got %b want 1", sr_err); end
      if (cwp !== CW'(5))    begin n_err++; $display("FAIL sr_cwp got %0d want 5", cwp); end
      if (trap_ovf !== 1'b0) begin n_err++; $display("FAIL sr_no_ovf got %b want 0", trap_ovf); end
      if (trap_unf !== 1'b0) begin n_err++; $display("FAIL sr_no_unf got %b want 0", trap_unf); end
      if (rs1_data !== 32'h600D_F00D) begin n_err++; $display("FAIL sr_rs1 got %h want 600df00d", rs1_data); end
      set_wim(8'h81);
      cycle(1, 1, 0, 0, '0, 1, 1, 0, '0);
      rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp += 6;
      if (sr_err !== 1'b0)   begin n_err++; $display("FAIL rst_mid_err got %b want 0", sr_err); end
      if (cwp !== '0)        begin n_err++; $display("FAIL rst_mid_cwp got %0d want 0", cwp); end
      if (wim !== '0)        begin n_err++; $display("FAIL rst_mid_wim got %h want 0", wim); end
      if (rs1_data !== '0)   begin n_err++; $display("FAIL rst_mid_rs1 got %h want 0", rs1_data); end
      if (rs2_data !== '0)   begin n_err++; $display("FAIL rst_mid_rs2 got %h want 0", rs2_data); end
      if (trap_ovf !== 1'b0 || trap_unf !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_traps got %b%b want 00", trap_ovf, trap_unf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1, 0, 0, 0, '0, 0, 0, 0, '0);
      n_cmp++;
      if (rs1_data !== 32'h600D_F00D) begin n_err++; $display("FAIL rst_keeps_array got %h want 600df00d", rs1_data); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      fill_all();
      test_globals();
      test_overlap();
      test_wrap();
      test_traps();
      test_wim_same_cycle();
      test_bypass();
      test_random();
      test_sr_err();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
